// File: rtl/tcb_lite_lib_misalign_splitter_if.sv
// Bus bundle for the misalign splitter: logsize request side (sub_*) and
// aligned byte-enable transfer side (man_*).
interface tcb_lite_lib_misalign_splitter_if #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32
);
  localparam int unsigned BEN = DAT / 8;

  logic           sub_vld;
  logic           sub_rdy;
  logic           sub_wen;
  logic [ADR-1:0] sub_adr;
  logic [1:0]     sub_siz;
  logic [DAT-1:0] sub_wdt;
  logic           sub_rsp;
  logic [DAT-1:0] sub_rdt;
  logic           sub_err;

  logic           man_vld;
  logic           man_rdy;
  logic           man_wen;
  logic [ADR-1:0] man_adr;
  logic [BEN-1:0] man_byt;
  logic [DAT-1:0] man_wdt;
  logic [DAT-1:0] man_rdt;
  logic           man_err;

  // master: the surrounding system (logsize manager plus aligned memory)
  modport master (
    output sub_vld, sub_wen, sub_adr, sub_siz, sub_wdt,
    input  sub_rdy, sub_rsp, sub_rdt, sub_err,
    input  man_vld, man_wen, man_adr, man_byt, man_wdt,
    output man_rdy, man_rdt, man_err
  );

  // slave: the splitter itself
  modport slave (
    input  sub_vld, sub_wen, sub_adr, sub_siz, sub_wdt,
    output sub_rdy, sub_rsp, sub_rdt, sub_err,
    output man_vld, man_wen, man_adr, man_byt, man_wdt,
    input  man_rdy, man_rdt, man_err
  );
endinterface

// File: rtl/tcb_lite_lib_misalign_splitter.sv
// Splits logsize requests at any byte alignment into one or two aligned
// byte-enable transfers and merges the read data into one right-justified response.
module tcb_lite_lib_misalign_splitter #(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned DLY = 1
)(
  input  logic clk,
  input  logic rst,
  tcb_lite_lib_misalign_splitter_if.slave bus
);
  localparam int unsigned BEN = DAT / 8;
  localparam int unsigned OFW = $clog2(BEN);

  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, RSP} state_t;
  state_t state, state_nxt;

  logic           req_wen;
  logic [ADR-1:0] req_adr;
  logic [1:0]     req_siz;
  logic [DAT-1:0] req_wdt;
  logic           req_ill;

  logic [OFW-1:0]   off;
  int unsigned      n;
  logic             split;
  logic [ADR-1:0]   adr0, adr1;
  logic [2*BEN-1:0] byt_w;
  logic [2*DAT-1:0] wdt_w;
  logic             ill_in, accept;

  logic             vld_int, hs, hs_idx;
  logic             mat_vld, mat_idx;
  logic [1:0]       pend, pend_nxt;
  logic             done;

  logic [DAT-1:0]   rdt0, rdt1, rdt_m;
  logic             err0, err1;

  assign ill_in = 32'(bus.sub_siz) > OFW;
  assign accept = (state == IDLE) && bus.sub_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_wen <= 1'b0;
      req_adr <= '0;
      req_siz <= '0;
      req_wdt <= '0;
      req_ill <= 1'b0;
    end else if (accept) begin
      req_wen <= bus.sub_wen;
      req_adr <= bus.sub_adr;
      req_siz <= bus.sub_siz;
      req_wdt <= bus.sub_wdt;
      req_ill <= ill_in;
    end
  end

  // Both words come from one double-width shift: the low half is word0, the high half word1.
  always_comb begin
    off   = req_adr[OFW-1:0];
    n     = 32'd1 << req_siz;
    split = (32'(off) + n) > BEN;
    adr0  = {req_adr[ADR-1:OFW], {OFW{1'b0}}};
    adr1  = adr0 + ADR'(BEN);
    byt_w = '0;
    for (int unsigned i = 0; i < BEN; i++) begin
      if (i < n) byt_w[i] = 1'b1;
    end
    byt_w = byt_w << off;
    wdt_w = {{DAT{1'b0}}, req_wdt} << (8 * 32'(off));
  end

  assign hs     = vld_int && bus.man_rdy;
  assign hs_idx = (state == HI);

  // Response tags travel DLY cycles behind their handshake.
  generate
    if (DLY == 0) begin : g_nodly
      always_comb begin
        mat_vld = hs;
        mat_idx = hs_idx;
      end
    end else begin : g_dly
      logic [DLY-1:0] pipe_vld, pipe_idx;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe_vld <= '0;
          pipe_idx <= '0;
        end else begin
          pipe_vld[0] <= hs;
          pipe_idx[0] <= hs_idx;
          for (int unsigned i = 1; i < DLY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_idx[i] <= pipe_idx[i-1];
          end
        end
      end
      always_comb begin
        mat_vld = pipe_vld[DLY-1];
        mat_idx = pipe_idx[DLY-1];
      end
    end
  endgenerate

  always_comb begin
    pend_nxt = pend;
    if (hs && !mat_vld)      pend_nxt = pend + 2'd1;
    else if (!hs && mat_vld) pend_nxt = pend - 2'd1;
    done = (pend_nxt == 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= pend_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdt0 <= '0;
      rdt1 <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (accept) begin
      rdt0 <= '0;
      rdt1 <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else if (mat_vld) begin
      if (mat_idx) begin
        rdt1 <= bus.man_rdt;
        err1 <= bus.man_err;
      end else begin
        rdt0 <= bus.man_rdt;
        err0 <= bus.man_err;
      end
    end
  end

  always_comb begin
    rdt_m = DAT'({rdt1, rdt0} >> (8 * 32'(off)));
    for (int unsigned i = 0; i < BEN; i++) begin
      if (i >= n) rdt_m[8*i +: 8] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A final transfer whose response lands in its own handshake cycle skips WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.sub_vld) state_nxt = ill_in ? RSP : LO;
      LO:   if (bus.man_rdy) state_nxt = split ? HI : (done ? RSP : WAIT);
      HI:   if (bus.man_rdy) state_nxt = done ? RSP : WAIT;
      WAIT: if (done) state_nxt = RSP;
      RSP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_int     = (state == LO) || (state == HI);
    bus.man_vld = vld_int;
    bus.man_wen = req_wen;
    bus.man_adr = (state == HI) ? adr1 : adr0;
    bus.man_byt = '0;
    bus.man_wdt = '0;
    if (state == LO) begin
      bus.man_byt = byt_w[BEN-1:0];
      bus.man_wdt = wdt_w[DAT-1:0];
    end else if (state == HI) begin
      bus.man_byt = byt_w[2*BEN-1:BEN];
      bus.man_wdt = wdt_w[2*DAT-1:DAT];
    end
    bus.sub_rdy = (state == IDLE);
    bus.sub_rsp = (state == RSP);
    bus.sub_err = (state == RSP) && (req_ill || err0 || err1);
    bus.sub_rdt = ((state == RSP) && !req_wen && !req_ill) ? rdt_m : '0;
  end
endmodule

// File: tb/tb_tcb_lite_lib_misalign_splitter.sv
// Directed scoreboard bench for the misalign splitter against a byte-addressed memory.
module tb_tcb_lite_lib_misalign_splitter;
  localparam int unsigned ADR = 32;
  localparam int unsigned DAT = 32;
  localparam int unsigned DLY = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tcb_lite_lib_misalign_splitter_if #(.ADR(ADR), .DAT(DAT)) bus ();
  tcb_lite_lib_misalign_splitter #(.ADR(ADR), .DAT(DAT), .DLY(DLY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {logic wen; logic [31:0] adr; logic [3:0] byt; logic [31:0] wdt;} xfer_t;
  typedef struct {logic [31:0] rdt; logic err; int lat;} rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  int    hq[$];
  bit [7:0] mem     [bit [31:0]];
  bit [7:0] ref_mem [bit [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic  prev_stall = 1'b0;
  xfer_t prev_x, mx;
  rsp_t  mr;
  int    mh;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input bit [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] byt);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{byt[i]}};
    return m;
  endfunction

  // man_rdy pattern: 0 always high, 1 high one cycle in three, 2 held low
  always @(posedge clk) begin
    cyc++;
    #1;
    case (rdy_mode)
      0:       bus.man_rdy = 1'b1;
      1:       bus.man_rdy = (cyc % 3 == 0);
      default: bus.man_rdy = 1'b0;
    endcase
  end

  // Memory subordinate: answers one cycle after the handshake, garbage otherwise; word 0x80 errors
  always @(posedge clk) begin : responder
    logic [31:0] rd;
    bit   [31:0] a;
    if (bus.man_vld === 1'b1 && bus.man_rdy === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        a = bus.man_adr + 32'(i);
        if (bus.man_wen && bus.man_byt[i]) mem[a] = bus.man_wdt[8*i +: 8];
        rd[8*i +: 8] = mem_rd(a);
      end
      bus.man_rdt <= bus.man_wen ? 32'h0 : rd;
      bus.man_err <= (bus.man_adr == 32'h80);
    end else begin
      bus.man_rdt <= 32'hDEADBEEF;
      bus.man_err <= 1'b1;
    end
  end

  // Byte-walk reference: each request byte is routed to whichever aligned word holds it
  task automatic push_req(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                          input logic [31:0] wdt, input bit timed);
    xfer_t x0, x1;
    rsp_t  r;
    bit    use1;
    int    n;
    logic [31:0] a;
    r.rdt = '0;
    if (siz == 2'd3) begin
      r.err = 1'b1;
      r.lat = timed ? 1 : -1;
      rq.push_back(r);
      return;
    end
    n = 1 << siz;
    x0.wen = wen; x0.adr = adr & ~32'h3; x0.byt = '0; x0.wdt = '0;
    x1.wen = wen; x1.adr = x0.adr + 32'd4; x1.byt = '0; x1.wdt = '0;
    use1 = 1'b0;
    for (int k = 0; k < n; k++) begin
      a = adr + 32'(k);
      if ((a & ~32'h3) == x0.adr) begin
        x0.byt[a[1:0]] = 1'b1;
        x0.wdt[8*a[1:0] +: 8] = wdt[8*k +: 8];
      end else begin
        use1 = 1'b1;
        x1.byt[a[1:0]] = 1'b1;
        x1.wdt[8*a[1:0] +: 8] = wdt[8*k +: 8];
      end
      if (wen) ref_mem[a] = wdt[8*k +: 8];
      else     r.rdt[8*k +: 8] = ref_rd(a);
    end
    r.err = (x0.adr == 32'h80) || (use1 && x1.adr == 32'h80);
    r.lat = !timed ? -1 : (use1 ? int'(DLY) + 3 : int'(DLY) + 2);
    xq.push_back(x0);
    if (use1) xq.push_back(x1);
    rq.push_back(r);
  endtask

  task automatic req(input logic wen, input logic [31:0] adr, input logic [1:0] siz,
                     input logic [31:0] wdt, input bit timed);
    bit got = 1'b0;
    push_req(wen, adr, siz, wdt, timed);
    @(posedge clk); #1;
    bus.sub_vld = 1'b1; bus.sub_wen = wen; bus.sub_adr = adr;
    bus.sub_siz = siz;  bus.sub_wdt = wdt;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.sub_rdy === 1'b1) begin
        hq.push_back(cyc);
        got = 1'b1;
      end
    end
    chk("sub_handshake", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.sub_vld = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (rq.size() == 0);
    end
    chk("rsp_timeout", 64'(ok), 64'd1);
    chk("xfers_left", 64'(xq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.man_vld === 1'b1) begin
        chk("xfer_expected", 64'(xq.size() != 0), 64'd1);
        if (prev_stall) begin
          chk("stall_adr", 64'(bus.man_adr), 64'(prev_x.adr));
          chk("stall_byt", 64'(bus.man_byt), 64'(prev_x.byt));
          chk("stall_wdt", 64'(bus.man_wdt), 64'(prev_x.wdt));
        end
        if (bus.man_rdy === 1'b1 && xq.size() != 0) begin
          mx = xq.pop_front();
          chk("xfer_wen", 64'(bus.man_wen), 64'(mx.wen));
          chk("xfer_adr", 64'(bus.man_adr), 64'(mx.adr));
          chk("xfer_byt", 64'(bus.man_byt), 64'(mx.byt));
          if (mx.wen) chk("xfer_wdt", 64'(bus.man_wdt & lane_mask(mx.byt)), 64'(mx.wdt));
        end
      end else if (prev_stall) begin
        chk("vld_held", 64'(bus.man_vld), 64'd1);
      end
      prev_stall = (bus.man_vld === 1'b1) && (bus.man_rdy !== 1'b1);
      prev_x.adr = bus.man_adr;
      prev_x.byt = bus.man_byt;
      prev_x.wdt = bus.man_wdt;
      if (bus.sub_rsp !== 1'b0) begin
        chk("rsp_expected", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0 && hq.size() != 0) begin
          mr = rq.pop_front();
          mh = hq.pop_front();
          chk("rsp_rdt", 64'(bus.sub_rdt), 64'(mr.rdt));
          chk("rsp_err", 64'(bus.sub_err), 64'(mr.err));
          if (mr.lat >= 0) chk("rsp_latency", 64'(cyc - mh), 64'(mr.lat));
        end
      end
    end
  end

  initial begin
    bus.sub_vld = 1'b0; bus.sub_wen = 1'b0; bus.sub_adr = '0;
    bus.sub_siz = '0;   bus.sub_wdt = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_sub_rdy", 64'(bus.sub_rdy), 64'd1);
    chk("reset_sub_rsp", 64'(bus.sub_rsp), 64'd0);
    chk("reset_sub_rdt", 64'(bus.sub_rdt), 64'd0);
    chk("reset_sub_err", 64'(bus.sub_err), 64'd0);
    chk("reset_man_vld", 64'(bus.man_vld), 64'd0);
    chk("reset_man_byt", 64'(bus.man_byt), 64'd0);
    rst = 1'b1;

    req(1'b1, 32'h30, 2'd2, 32'h76543210, 1'b1); wait_done();
    req(1'b0, 32'h30, 2'd2, 32'h0, 1'b1);        wait_done();

    req(1'b1, 32'h43, 2'd1, 32'h00007654, 1'b1); wait_done();
    req(1'b0, 32'h43, 2'd1, 32'h0, 1'b1);        wait_done();

    for (int a = 32'h51; a <= 32'h53; a++) begin
      req(1'b1, 32'(a), 2'd2, 32'h76543210, 1'b1); wait_done();
      req(1'b0, 32'(a), 2'd2, 32'h0, 1'b1);        wait_done();
    end

    // off+n==BEN stays a single transfer
    req(1'b1, 32'h62, 2'd1, 32'h0000BEEF, 1'b1); wait_done();
    req(1'b0, 32'h62, 2'd1, 32'h0, 1'b1);        wait_done();
    req(1'b0, 32'h63, 2'd0, 32'h0, 1'b1);        wait_done();

    req(1'b1, 32'h7C, 2'd2, 32'h11223344, 1'b1); wait_done();
    req(1'b0, 32'h7C, 2'd2, 32'h0, 1'b1);        wait_done();
    req(1'b0, 32'h82, 2'd2, 32'h0, 1'b1);        wait_done();
    req(1'b0, 32'h7E, 2'd2, 32'h0, 1'b1);        wait_done();

    rdy_mode = 1;
    req(1'b0, 32'h41, 2'd2, 32'h0, 1'b0);        wait_done();
    rdy_mode = 0;

    req(1'b1, 32'hFFFFFFFE, 2'd2, 32'hA5A5C3C3, 1'b1); wait_done();
    req(1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 1'b1);        wait_done();

    req(1'b0, 32'h30, 2'd3, 32'h0, 1'b1); wait_done();

    // reset while HI is stalled and word0's response is still in flight
    req(1'b0, 32'h41, 2'd2, 32'h0, 1'b0);
    #1 rdy_mode = 2;
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_man_vld", 64'(bus.man_vld), 64'd0);
    chk("midrst_man_byt", 64'(bus.man_byt), 64'd0);
    chk("midrst_sub_rdy", 64'(bus.sub_rdy), 64'd1);
    chk("midrst_sub_rsp", 64'(bus.sub_rsp), 64'd0);
    xq.delete();
    rq.delete();
    hq.delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    rdy_mode = 0;
    repeat (4) @(negedge clk);

    req(1'b0, 32'h30, 2'd2, 32'h0, 1'b1); wait_done();
    req(1'b0, 32'h43, 2'd1, 32'h0, 1'b1); wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time %0t required finish", $time);
    $fatal(1, "global timeout");
  end
endmodule
